// File: rtl/bicubic_job_sched.sv
// bicubic_job_sched: job queue, parameter range check and single-job launcher
// for the Bicubic upscaling engine. The engine is held in reset between jobs,
// released with stable parameters, and a tagged completion record is returned.
// Optional RUN-state watchdog: define BICUBIC_SCHED_TIMEOUT_EN to enable it.
module bicubic_job_sched #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd40000,
  parameter int unsigned IMG_W       = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_id,
  input  logic [6:0]  i_req_v0,
  input  logic [6:0]  i_req_h0,
  input  logic [4:0]  i_req_sw,
  input  logic [4:0]  i_req_sh,
  input  logic [5:0]  i_req_tw,
  input  logic [5:0]  i_req_th,
  output logic        o_eng_rst,
  output logic [6:0]  o_v0,
  output logic [6:0]  o_h0,
  output logic [4:0]  o_sw,
  output logic [4:0]  o_sh,
  output logic [5:0]  o_tw,
  output logic [5:0]  o_th,
  input  logic        i_eng_done,
  output logic        o_cpl_valid,
  input  logic        i_cpl_ready,
  output logic [1:0]  o_cpl_id,
  output logic [1:0]  o_cpl_err,
  output logic [15:0] o_cpl_cyc,
  output logic        o_busy
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam logic [7:0]  W_LIM = 8'(IMG_W - 1);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_PARAM = 2'b01;
`ifdef BICUBIC_SCHED_TIMEOUT_EN
  localparam logic [1:0] ERR_TMO   = 2'b10;
`endif

  typedef struct packed {
    logic [1:0] id;
    logic [6:0] v0;
    logic [6:0] h0;
    logic [4:0] sw;
    logic [4:0] sh;
    logic [5:0] tw;
    logic [5:0] th;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RSTE,
    S_RUN,
    S_CPL
  } state_t;

  job_t          r_q [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  job_t          r_job;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_eng_rst;
  logic          r_cpl_valid;
  logic [1:0]    r_cpl_id;
  logic [1:0]    r_cpl_err;
  logic [15:0]   r_cpl_cyc;
  logic [15:0]   r_run_cyc;
  logic          r_rste_cnt;

  logic          w_push;
  logic          w_pop;
  job_t          w_req_job;
  job_t          w_head;
  logic [7:0]    w_h_end;
  logic [7:0]    w_v_end;
  logic          w_params_ok;
  logic [15:0]   w_cyc_inc;
  logic          w_eng_rst_nxt;
  logic          w_cpl_valid_nxt;
  logic [1:0]    w_cpl_id_nxt;
  logic [1:0]    w_cpl_err_nxt;
  logic [15:0]   w_cpl_cyc_nxt;
  logic [15:0]   w_run_cyc_nxt;
  logic          w_rste_cnt_nxt;

`ifndef BICUBIC_SCHED_TIMEOUT_EN
  logic          w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYC;
`endif

  assign o_req_ready = (r_count != CW'(DEPTH)) & i_rst_n;
  assign w_push      = i_req_valid & o_req_ready;
  assign w_req_job   = {i_req_id, i_req_v0, i_req_h0, i_req_sw, i_req_sh, i_req_tw, i_req_th};
  assign w_head      = r_q[r_rd_ptr];

  assign o_eng_rst   = r_eng_rst;
  assign o_v0        = r_job.v0;
  assign o_h0        = r_job.h0;
  assign o_sw        = r_job.sw;
  assign o_sh        = r_job.sh;
  assign o_tw        = r_job.tw;
  assign o_th        = r_job.th;
  assign o_cpl_valid = r_cpl_valid;
  assign o_cpl_id    = r_cpl_id;
  assign o_cpl_err   = r_cpl_err;
  assign o_cpl_cyc   = r_cpl_cyc;
  assign o_busy      = (r_state != S_IDLE) || (r_count != '0);

  // Window end sums at 8 bits; 7-bit origin plus 5-bit size cannot overflow.
  assign w_h_end     = 8'(r_job.h0) + 8'(r_job.sw);
  assign w_v_end     = 8'(r_job.v0) + 8'(r_job.sh);
  assign w_params_ok = (r_job.sw >= 5'd2) && (r_job.sh >= 5'd2) &&
                       (r_job.tw >= 6'd2) && (r_job.th >= 6'd2) &&
                       (r_job.h0 >= 7'd2) && (r_job.v0 >= 7'd2) &&
                       (w_h_end <= W_LIM) && (w_v_end <= W_LIM);

  assign w_cyc_inc   = (r_run_cyc == 16'hFFFF) ? 16'hFFFF : r_run_cyc + 16'd1;

  // Queue storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q[r_wr_ptr] <= w_req_job;
    end
  end

  // Queue pointers and occupancy; reset flushes any queued jobs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Parameter registers: loaded only when a job is popped, held otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_job <= '0;
    end else if (w_pop) begin
      r_job <= w_head;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, engine reset and completion record logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_eng_rst_nxt   = 1'b1;
    w_cpl_valid_nxt = 1'b0;
    w_cpl_id_nxt    = r_cpl_id;
    w_cpl_err_nxt   = r_cpl_err;
    w_cpl_cyc_nxt   = r_cpl_cyc;
    w_run_cyc_nxt   = r_run_cyc;
    w_rste_cnt_nxt  = r_rste_cnt;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!w_params_ok) begin
          w_cpl_valid_nxt = 1'b1;
          w_cpl_id_nxt    = r_job.id;
          w_cpl_err_nxt   = ERR_PARAM;
          w_cpl_cyc_nxt   = 16'd0;
          w_state_nxt     = S_CPL;
        end else begin
          w_rste_cnt_nxt  = 1'b0;
          w_state_nxt     = S_RSTE;
        end
      end
      S_RSTE: begin
        if (r_rste_cnt) begin
          w_eng_rst_nxt  = 1'b0;
          w_run_cyc_nxt  = 16'd0;
          w_state_nxt    = S_RUN;
        end else begin
          w_rste_cnt_nxt = 1'b1;
        end
      end
      S_RUN: begin
        w_eng_rst_nxt = 1'b0;
        w_run_cyc_nxt = w_cyc_inc;
        if (i_eng_done) begin
          w_eng_rst_nxt   = 1'b1;
          w_cpl_valid_nxt = 1'b1;
          w_cpl_id_nxt    = r_job.id;
          w_cpl_err_nxt   = ERR_OK;
          w_cpl_cyc_nxt   = w_cyc_inc;
          w_state_nxt     = S_CPL;
        end
`ifdef BICUBIC_SCHED_TIMEOUT_EN
        else if (w_cyc_inc == TIMEOUT_CYC) begin
          w_eng_rst_nxt   = 1'b1;
          w_cpl_valid_nxt = 1'b1;
          w_cpl_id_nxt    = r_job.id;
          w_cpl_err_nxt   = ERR_TMO;
          w_cpl_cyc_nxt   = TIMEOUT_CYC;
          w_state_nxt     = S_CPL;
        end
`endif
      end
      S_CPL: begin
        if (i_cpl_ready) begin
          w_state_nxt     = S_IDLE;
        end else begin
          w_cpl_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered engine reset, completion record and RUN cycle counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_eng_rst   <= 1'b1;
      r_cpl_valid <= 1'b0;
      r_cpl_id    <= 2'd0;
      r_cpl_err   <= 2'd0;
      r_cpl_cyc   <= 16'd0;
      r_run_cyc   <= 16'd0;
      r_rste_cnt  <= 1'b0;
    end else begin
      r_eng_rst   <= w_eng_rst_nxt;
      r_cpl_valid <= w_cpl_valid_nxt;
      r_cpl_id    <= w_cpl_id_nxt;
      r_cpl_err   <= w_cpl_err_nxt;
      r_cpl_cyc   <= w_cpl_cyc_nxt;
      r_run_cyc   <= w_run_cyc_nxt;
      r_rste_cnt  <= w_rste_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bicubic_job_sched.sv
// tb_bicubic_job_sched: randomized bench for bicubic_job_sched with a
// queue-based reference model of job acceptance, checks and completions.
`timescale 1ns/1ps
module tb_bicubic_job_sched;

  localparam int DEPTH = 4;
  localparam int IMG_W = 100;
  localparam int TMO   = 100;

  typedef struct {
    int id;
    int v0;
    int h0;
    int sw;
    int sh;
    int tw;
    int th;
    int dly;
    int err;
    int cyc;
  } job_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_id;
  logic [6:0]  req_v0;
  logic [6:0]  req_h0;
  logic [4:0]  req_sw;
  logic [4:0]  req_sh;
  logic [5:0]  req_tw;
  logic [5:0]  req_th;
  logic        eng_rst;
  logic [6:0]  v0;
  logic [6:0]  h0;
  logic [4:0]  sw;
  logic [4:0]  sh;
  logic [5:0]  tw;
  logic [5:0]  th;
  logic        eng_done;
  logic        cpl_valid;
  logic        cpl_ready;
  logic [1:0]  cpl_id;
  logic [1:0]  cpl_err;
  logic [15:0] cpl_cyc;
  logic        busy;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   rdy_mode = 1;
  job_t exp_q[$];
  job_t run_q[$];

  bicubic_job_sched #(
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (16'(TMO)),
    .IMG_W       (IMG_W)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_id    (req_id),
    .i_req_v0    (req_v0),
    .i_req_h0    (req_h0),
    .i_req_sw    (req_sw),
    .i_req_sh    (req_sh),
    .i_req_tw    (req_tw),
    .i_req_th    (req_th),
    .o_eng_rst   (eng_rst),
    .o_v0        (v0),
    .o_h0        (h0),
    .o_sw        (sw),
    .o_sh        (sh),
    .o_tw        (tw),
    .o_th        (th),
    .i_eng_done  (eng_done),
    .o_cpl_valid (cpl_valid),
    .i_cpl_ready (cpl_ready),
    .o_cpl_id    (cpl_id),
    .o_cpl_err   (cpl_err),
    .o_cpl_cyc   (cpl_cyc),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference outcome of a job from its parameters and engine latency.
  function automatic job_t mk_job(input int id, input int jv0, input int jh0, input int jsw,
                                  input int jsh, input int jtw, input int jth, input int dly);
    job_t j;
    bit   ok;
    j = '{id: id, v0: jv0, h0: jh0, sw: jsw, sh: jsh, tw: jtw, th: jth, dly: dly, err: 0, cyc: 0};
    ok = (jsw >= 2) && (jsh >= 2) && (jtw >= 2) && (jth >= 2) && (jh0 >= 2) && (jv0 >= 2) &&
         (jh0 + jsw <= IMG_W - 1) && (jv0 + jsh <= IMG_W - 1);
    if (!ok) begin
      j.err = 1;
      j.cyc = 0;
    end else begin
`ifdef BICUBIC_SCHED_TIMEOUT_EN
      if (dly == 0 || dly > TMO) begin
        j.err = 2;
        j.cyc = TMO;
      end else begin
        j.err = 0;
        j.cyc = dly;
      end
`else
      j.err = 0;
      j.cyc = dly;
`endif
    end
    return j;
  endfunction

  // Offer one job, wait (bounded) for acceptance, then record its expected outcome.
  task automatic push_job(input int id, input int jv0, input int jh0, input int jsw,
                          input int jsh, input int jtw, input int jth, input int dly);
    job_t j;
    int   n;
    j = mk_job(id, jv0, jh0, jsw, jsh, jtw, jth, dly);
    req_id = 2'(id); req_v0 = 7'(jv0); req_h0 = 7'(jh0); req_sw = 5'(jsw);
    req_sh = 5'(jsh); req_tw = 6'(jtw); req_th = 6'(jth);
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      chk("push_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(j);
    if (j.err != 1) run_q.push_back(j);
  endtask

  task automatic wait_run(input int limit);
    int n;
    n = 0;
    while (eng_rst !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (eng_rst !== 1'b0) chk("wait_run_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy !== 1'b0) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Engine model: pulses DONE in the dly-th cycle of RUN; dly 0 never finishes.
  initial begin
    int   run_cnt;
    job_t cur;
    eng_done = 1'b0;
    run_cnt  = 0;
    cur      = '{default: 0};
    forever begin
      @(posedge clk); #1;
      eng_done = 1'b0;
      if (eng_rst !== 1'b0) begin
        run_cnt = 0;
      end else begin
        if (run_cnt == 0) begin
          if (run_q.size() == 0) begin
            chk("unexpected_run", 1, 0);
            cur = '{default: 0};
          end else begin
            cur = run_q.pop_front();
            chk("run_v0", int'(v0), cur.v0);
            chk("run_h0", int'(h0), cur.h0);
            chk("run_sw", int'(sw), cur.sw);
            chk("run_sh", int'(sh), cur.sh);
            chk("run_tw", int'(tw), cur.tw);
            chk("run_th", int'(th), cur.th);
          end
        end
        run_cnt++;
        if (cur.dly != 0 && run_cnt == cur.dly) eng_done = 1'b1;
      end
    end
  end

  // Completion host: ready policy selected by rdy_mode (0 low, 1 high, 2 random).
  initial begin
    cpl_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       cpl_ready = 1'b0;
        1:       cpl_ready = 1'b1;
        default: cpl_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Completion scoreboard: record must match the oldest outstanding job while valid.
  initial begin
    bit prev_hs;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_hs) chk("cpl_release", int'(cpl_valid), 0);
      prev_hs = 1'b0;
      if (rst_n === 1'b1 && cpl_valid === 1'b1) begin
        chk("cpl_eng_rst", int'(eng_rst), 1);
        if (exp_q.size() == 0) begin
          chk("cpl_unexpected", 1, 0);
        end else begin
          chk("cpl_id", int'(cpl_id), exp_q[0].id);
          chk("cpl_err", int'(cpl_err), exp_q[0].err);
          chk("cpl_cyc", int'(cpl_cyc), exp_q[0].cyc);
          if (cpl_ready === 1'b1) begin
            void'(exp_q.pop_front());
            prev_hs = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got %0d expected %0d", n_chk, -1);
    $fatal(1);
  end

  initial begin
    int rid, rv0, rh0, rsw, rsh, rtw, rth, rdly;
    rst_n = 1'b0; req_valid = 1'b0;
    req_id = '0; req_v0 = '0; req_h0 = '0; req_sw = '0; req_sh = '0; req_tw = '0; req_th = '0;

    // Reset behaviour
    idle_cycles(3);
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_eng_rst", int'(eng_rst), 1);
    chk("rst_cpl_valid", int'(cpl_valid), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_params", int'({v0, h0, sw, sh, tw, th}), 0);
    chk("rst_cpl_rec", int'({cpl_id, cpl_err, cpl_cyc}), 0);
    chk("rst_ready_hi", int'(req_ready), 1);
    @(posedge clk); #1;

    // Single good job and launch latency
    push_job(1, 10, 20, 5, 5, 12, 12, 500);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("launch_lat", int'(eng_rst), (i < 5) ? 1 : 0);
      if (i == 1) chk("busy_queued", int'(busy), 1);
    end
    @(posedge clk); #1;
    wait_idle(1000);
    @(posedge clk); #1;

    // Queue full while a job runs
    push_job(2, 30, 30, 8, 8, 20, 20, 300);
    wait_run(20);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_job(i, 5 + i, 6 + i, 4, 4, 10, 10, 5);
    @(negedge clk);
    chk("full_ready", int'(req_ready), 0);
    chk("full_busy", int'(busy), 1);
    @(posedge clk); #1;
    push_job(0, 40, 41, 9, 9, 30, 30, 6);
    wait_idle(2000);
    @(posedge clk); #1;

    // Parameter rejects followed by a good job
    push_job(2, 10, 20, 5, 5, 1, 12, 9);
    push_job(3, 10, 98, 5, 5, 12, 12, 9);
    push_job(0, 10, 20, 5, 5, 12, 12, 7);
    wait_idle(500);
    @(posedge clk); #1;

    // Completion backpressure
    rdy_mode = 0;
    push_job(1, 12, 12, 6, 6, 16, 16, 20);
    push_job(2, 14, 14, 6, 6, 16, 16, 11);
    begin
      int n;
      n = 0;
      while (cpl_valid !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (cpl_valid !== 1'b1) chk("bp_wait_timeout", 0, 1);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("bp_eng_rst", int'(eng_rst), 1);
      chk("bp_valid", int'(cpl_valid), 1);
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    wait_idle(500);
    @(posedge clk); #1;

    // Randomized traffic with random completion backpressure
    rdy_mode = 2;
    for (int k = 0; k < 30; k++) begin
      rid  = $urandom_range(0, 3);
      rdly = $urandom_range(1, 40);
      if ($urandom_range(0, 4) == 0) begin
        rv0 = $urandom_range(0, 127); rh0 = $urandom_range(0, 127);
        rsw = $urandom_range(0, 31);  rsh = $urandom_range(0, 31);
        rtw = $urandom_range(0, 63);  rth = $urandom_range(0, 63);
      end else begin
        rv0 = $urandom_range(2, 60); rh0 = $urandom_range(2, 60);
        rsw = $urandom_range(2, 31); rsh = $urandom_range(2, 31);
        rtw = $urandom_range(2, 63); rth = $urandom_range(2, 63);
      end
      push_job(rid, rv0, rh0, rsw, rsh, rtw, rth, rdly);
      idle_cycles($urandom_range(0, 6));
    end
    wait_idle(5000);
    rdy_mode = 1;
    @(posedge clk); #1;

`ifdef BICUBIC_SCHED_TIMEOUT_EN
    // Watchdog: the engine never signals DONE
    push_job(3, 20, 20, 5, 5, 12, 12, 0);
    wait_idle(500);
    @(posedge clk); #1;
`endif

    // Reset in the middle of a run with jobs still queued
    push_job(1, 10, 10, 5, 5, 12, 12, 1000);
    wait_run(20);
    @(posedge clk); #1;
    push_job(2, 11, 11, 5, 5, 12, 12, 5);
    push_job(3, 12, 12, 5, 5, 12, 12, 5);
    rst_n = 1'b0;
    exp_q.delete();
    run_q.delete();
    @(negedge clk);
    chk("mid_rst_ready", int'(req_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_eng_rst", int'(eng_rst), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cpl_valid", int'(cpl_valid), 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", int'({busy, cpl_valid, ~eng_rst}), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
